// File: rtl/hit_classifier.sv
// hit_classifier
//   Upstream stage of combo_counter. Tracks which holes have a mole up,
//   edge-detects button presses and turns each accepted press (and, when
//   enabled, each unwhacked expiry) into one-cycle result pulses. At most one
//   of miss / non_full_clear_hit / full_clear_hit is high in any cycle.
//
// Parameters
//   N_HOLES         number of holes/buttons (2..16)
//   LOCKOUT_CYCLES  cycles after a classified press during which presses are ignored (>=1)
//
// Ports
//   clk                 in   system clock
//   rst                 in   synchronous active-high reset
//   btn                 in   debounced button levels, 1 = pressed
//   mole_spawn          in   one-cycle pulses: raise mole i
//   mole_expire         in   one-cycle pulses: mole i timed out
//   mole_up             out  registered mask of moles currently up
//   miss                out  pulse: bad press, mash, or expiry-miss
//   non_full_clear_hit  out  pulse: mole hit, other moles remain up
//   full_clear_hit      out  pulse: hit the last mole up
//   lockout             out  high while the press lockout counter is nonzero
//
// Build option
//   EXPIRE_MISS_EN  when defined, every valid expiry queues a miss pulse in a
//                   saturating pending counter drained on cycles without a
//                   press result. Undefined: expiry only clears mole_up.
module hit_classifier #(
  parameter int unsigned N_HOLES        = 8,
  parameter int unsigned LOCKOUT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_HOLES-1:0] btn,
  input  logic [N_HOLES-1:0] mole_spawn,
  input  logic [N_HOLES-1:0] mole_expire,
  output logic [N_HOLES-1:0] mole_up,
  output logic               miss,
  output logic               non_full_clear_hit,
  output logic               full_clear_hit,
  output logic               lockout
);

  localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

  logic [N_HOLES-1:0] btn_q, btn_d;
  logic [N_HOLES-1:0] mole_up_q, mole_up_d;
  logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic               miss_q, miss_d;
  logic               nfch_q, nfch_d;
  logic               fch_q, fch_d;

  logic [N_HOLES-1:0] press;
  logic [N_HOLES-1:0] hit_clear;
  logic               accept;
  logic               multi;

`ifdef EXPIRE_MISS_EN
  localparam int unsigned PEND_W   = $clog2(N_HOLES * 2 + 1);
  localparam int unsigned SUM_W    = PEND_W + 1;
  localparam int unsigned PEND_MAX = (1 << PEND_W) - 1;

  logic [PEND_W-1:0]  pend_q, pend_d;
  logic [N_HOLES-1:0] exp_valid;
  logic [SUM_W-1:0]   exp_cnt;
  logic [SUM_W-1:0]   pend_sum;
  logic               drain;
`endif

  always_comb begin
    btn_d     = btn;
    press     = btn & ~btn_q;
    accept    = (lock_cnt_q == '0) && (press != '0);
    // More than one bit set iff clearing the lowest set bit leaves something.
    multi     = (press & (press - N_HOLES'(1))) != '0;
    hit_clear = '0;
    miss_d    = 1'b0;
    nfch_d    = 1'b0;
    fch_d     = 1'b0;

    if (accept) begin
      if (multi) begin
        miss_d = 1'b1;
      end else if ((press & mole_up_q) == '0) begin
        miss_d = 1'b1;
      end else begin
        hit_clear = press;
        if ((mole_up_q & ~press) == '0) fch_d  = 1'b1;
        else                            nfch_d = 1'b1;
      end
    end

    // Hit clear, then expiry clear, then spawn: spawn wins on a shared hole.
    mole_up_d = ((mole_up_q & ~hit_clear) & ~mole_expire) | mole_spawn;

    if (accept)                lock_cnt_d = LOCK_W'(LOCKOUT_CYCLES);
    else if (lock_cnt_q != '0) lock_cnt_d = lock_cnt_q - LOCK_W'(1);
    else                       lock_cnt_d = lock_cnt_q;

`ifdef EXPIRE_MISS_EN
    // A hit on the expiring hole suppresses its expiry-miss.
    exp_valid = mole_expire & mole_up_q & ~hit_clear;
    exp_cnt   = '0;
    for (int unsigned i = 0; i < N_HOLES; i++) begin
      exp_cnt = exp_cnt + SUM_W'(exp_valid[i]);
    end
    drain = !accept && (pend_q != '0);
    if (drain) miss_d = 1'b1;
    pend_sum = {1'b0, pend_q} + exp_cnt - SUM_W'(drain);
    if (pend_sum > SUM_W'(PEND_MAX)) pend_d = '1;
    else                             pend_d = pend_sum[PEND_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q      <= '1;
      mole_up_q  <= '0;
      lock_cnt_q <= '0;
      miss_q     <= 1'b0;
      nfch_q     <= 1'b0;
      fch_q      <= 1'b0;
    end else begin
      btn_q      <= btn_d;
      mole_up_q  <= mole_up_d;
      lock_cnt_q <= lock_cnt_d;
      miss_q     <= miss_d;
      nfch_q     <= nfch_d;
      fch_q      <= fch_d;
    end
  end

`ifdef EXPIRE_MISS_EN
  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end
`endif

  assign mole_up            = mole_up_q;
  assign miss               = miss_q;
  assign non_full_clear_hit = nfch_q;
  assign full_clear_hit     = fch_q;
  assign lockout            = (lock_cnt_q != '0);

endmodule

// File: tb/tb_hit_classifier.sv
// tb_hit_classifier
//   Directed bench for hit_classifier with N_HOLES=4, LOCKOUT_CYCLES=3.
//   Stimulus pushes expected result pulses into a queue; a negedge monitor
//   pops and compares whenever a pulse appears, and flags pulses that never
//   arrive. Lockout and mole_up levels are also checked directly.
module tb_hit_classifier;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] mole_spawn;
  logic [3:0] mole_expire;
  logic [3:0] mole_up;
  logic       miss;
  logic       non_full_clear_hit;
  logic       full_clear_hit;
  logic       lockout;

  hit_classifier #(
    .N_HOLES       (4),
    .LOCKOUT_CYCLES(3)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .btn               (btn),
    .mole_spawn        (mole_spawn),
    .mole_expire       (mole_expire),
    .mole_up           (mole_up),
    .miss              (miss),
    .non_full_clear_hit(non_full_clear_hit),
    .full_clear_hit    (full_clear_hit),
    .lockout           (lockout)
  );

  // Pulse code order: {miss, non_full_clear_hit, full_clear_hit}
  localparam logic [2:0] P_MISS = 3'b100;
  localparam logic [2:0] P_NFCH = 3'b010;
  localparam logic [2:0] P_FCH  = 3'b001;

  typedef struct {
    int         cycle;
    logic [2:0] pulses;
    logic [3:0] mole_up;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   n_checks;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input int at_cycle, input logic [2:0] p, input logic [3:0] m);
    exp_t e;
    e.cycle   = at_cycle;
    e.pulses  = p;
    e.mole_up = m;
    q.push_back(e);
  endtask

  // Monitor: compares every presented pulse against the scoreboard.
  always @(negedge clk) begin
    logic [2:0] p;
    exp_t       e;
    p = {miss, non_full_clear_hit, full_clear_hit};
    if (p != 3'b000) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {29'd0, p}, 32'd0);
      end else begin
        e = q.pop_front();
        check("pulse_kind", {29'd0, p}, {29'd0, e.pulses});
        check("pulse_cycle", cyc, e.cycle);
        check("pulse_mole_up", {28'd0, mole_up}, {28'd0, e.mole_up});
      end
    end else if (q.size() > 0 && q[0].cycle < cyc) begin
      e = q.pop_front();
      check("missing_pulse", 32'd0, {29'd0, e.pulses});
    end
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    btn         = 4'b0000;
    mole_spawn  = 4'b0000;
    mole_expire = 4'b0000;

    // 1. Reset, spawn 0011, hit hole 0.
    tick();
    tick();
    check("reset_mole_up", {28'd0, mole_up}, 32'd0);
    check("reset_lockout", {31'd0, lockout}, 32'd0);
    check("reset_pulses", {29'd0, miss, non_full_clear_hit, full_clear_hit}, 32'd0);
    rst        = 1'b0;
    mole_spawn = 4'b0011;
    tick();
    check("spawn_mole_up", {28'd0, mole_up}, 32'h3);
    mole_spawn = 4'b0000;
    btn        = 4'b0001;
    expect_pulse(cyc + 1, P_NFCH, 4'b0010);
    tick();
    // Press on hole 3 one cycle after the accepted press is dropped.
    btn = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      check("lockout_high", {31'd0, lockout}, 32'd1);
      tick();
    end
    check("lockout_clear", {31'd0, lockout}, 32'd0);
    check("after_hit_mole_up", {28'd0, mole_up}, 32'h2);

    // 2. Hit the last mole.
    btn = 4'b1011;
    expect_pulse(cyc + 1, P_FCH, 4'b0000);
    for (int i = 0; i < 4; i++) tick();
    check("full_clear_mole_up", {28'd0, mole_up}, 32'h0);

    // 3. Press on an empty hole.
    btn = 4'b0000;
    tick();
    btn = 4'b0100;
    expect_pulse(cyc + 1, P_MISS, 4'b0000);
    for (int i = 0; i < 4; i++) tick();
    btn = 4'b0000;
    tick();

    // 4. Mash two holes that both have moles.
    mole_spawn = 4'b0101;
    tick();
    mole_spawn = 4'b0000;
    btn        = 4'b0101;
    expect_pulse(cyc + 1, P_MISS, 4'b0101);
    tick();
    check("mash_mole_up", {28'd0, mole_up}, 32'h5);
    for (int i = 0; i < 3; i++) tick();
    btn = 4'b0000;
    tick();

    // 5. Reset during lockout while holding every button.
    btn = 4'b0001;
    expect_pulse(cyc + 1, P_NFCH, 4'b0100);
    tick();
    check("pre_reset_lockout", {31'd0, lockout}, 32'd1);
    btn = 4'b1111;
    rst = 1'b1;
    tick();
    check("mid_lockout_reset", {31'd0, lockout}, 32'd0);
    check("reset_clears_moles", {28'd0, mole_up}, 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    btn = 4'b0000;
    tick();

    // 6. Hit and expiry on different holes in the same cycle.
    mole_spawn = 4'b1001;
    tick();
    check("spawn_1001", {28'd0, mole_up}, 32'h9);
    mole_spawn  = 4'b0000;
    btn         = 4'b0001;
    mole_expire = 4'b1000;
    expect_pulse(cyc + 1, P_NFCH, 4'b0000);
`ifdef EXPIRE_MISS_EN
    expect_pulse(cyc + 2, P_MISS, 4'b0000);
`endif
    tick();
    mole_expire = 4'b0000;
    check("expire_hit_mole_up", {28'd0, mole_up}, 32'h0);
    for (int i = 0; i < 6; i++) tick();
    btn = 4'b0000;
    tick();
    tick();

    check("scoreboard_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
